// File: rtl/rv_wb_scoreboard.sv
// Write-back merge (ALU > LSU > MDU) onto the single register-file write port,
// plus a busy scoreboard for long-latency destinations that drives the issue stall.
module rv_wb_scoreboard #(
    parameter  int XLEN       = 32,
    parameter  int GPR_ADDR_W = 5,
    localparam int NUM_REGS   = 2**GPR_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  iss_valid_i,
    input  logic                  iss_long_i,
    input  logic [GPR_ADDR_W-1:0] iss_rd_i,
    input  logic [GPR_ADDR_W-1:0] iss_rs1_i,
    input  logic [GPR_ADDR_W-1:0] iss_rs2_i,
    output logic                  stall_o,
    input  logic                  alu_valid_i,
    input  logic [GPR_ADDR_W-1:0] alu_rd_i,
    input  logic [XLEN-1:0]       alu_data_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [GPR_ADDR_W-1:0] lsu_rd_i,
    input  logic [XLEN-1:0]       lsu_data_i,
    input  logic                  mdu_valid_i,
    output logic                  mdu_ready_o,
    input  logic [GPR_ADDR_W-1:0] mdu_rd_i,
    input  logic [XLEN-1:0]       mdu_data_i,
    output logic                  gpr_wr_en_o,
    output logic [GPR_ADDR_W-1:0] gpr_wr_addr_o,
    output logic [XLEN-1:0]       gpr_wr_data_o,
    output logic [NUM_REGS-1:0]   busy_o
);

    logic                  w_lsu_acc;
    logic                  w_mdu_acc;
    logic                  w_acc;
    logic                  w_acc_long;
    logic [GPR_ADDR_W-1:0] w_acc_rd;
    logic [XLEN-1:0]       w_acc_data;
    logic                  w_stall;
    logic                  w_issue_set;
    logic                  w_commit_clr;
    logic [NUM_REGS-1:0]   w_busy_next;

    logic                  r_wr_en;
    logic [GPR_ADDR_W-1:0] r_wr_addr;
    logic [XLEN-1:0]       r_wr_data;
    logic                  r_wb_long;
    logic [NUM_REGS-1:0]   r_busy;

    // The ALU cannot be back-pressured, so it always wins; LSU beats MDU.
    assign lsu_ready_o = !alu_valid_i;
    assign mdu_ready_o = !alu_valid_i && !lsu_valid_i;
    assign w_lsu_acc   = lsu_valid_i && lsu_ready_o;
    assign w_mdu_acc   = mdu_valid_i && mdu_ready_o;
    assign w_acc       = alu_valid_i || w_lsu_acc || w_mdu_acc;

    always_comb begin
        w_acc_rd   = mdu_rd_i;
        w_acc_data = mdu_data_i;
        w_acc_long = 1'b1;
        if (alu_valid_i) begin
            w_acc_rd   = alu_rd_i;
            w_acc_data = alu_data_i;
            w_acc_long = 1'b0;
        end else if (w_lsu_acc) begin
            w_acc_rd   = lsu_rd_i;
            w_acc_data = lsu_data_i;
            w_acc_long = 1'b1;
        end
    end

    // Stall looks only at registered busy: a result still in the write stage is not bypassed.
    assign w_stall      = iss_valid_i &&
                          (r_busy[iss_rs1_i] || r_busy[iss_rs2_i] || r_busy[iss_rd_i]);
    assign w_issue_set  = iss_valid_i && iss_long_i && !w_stall && (iss_rd_i != '0);
    assign w_commit_clr = r_wr_en && r_wb_long && r_busy[r_wr_addr];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            if (gi == 0) begin : g_x0
                assign w_busy_next[gi] = 1'b0;
            end else begin : g_xn
                // Set is ORed after the clear so a same-edge set wins.
                assign w_busy_next[gi] =
                    (w_issue_set && (iss_rd_i == GPR_ADDR_W'(gi))) ||
                    (r_busy[gi] && !(w_commit_clr && (r_wr_addr == GPR_ADDR_W'(gi))));
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wb_long <= 1'b0;
            r_busy    <= '0;
        end else begin
            r_wr_en <= w_acc && (w_acc_rd != '0);
            if (w_acc) begin
                r_wr_addr <= w_acc_rd;
                r_wr_data <= w_acc_data;
                r_wb_long <= w_acc_long;
            end
            r_busy <= w_busy_next;
        end
    end

    assign stall_o       = w_stall;
    assign gpr_wr_en_o   = r_wr_en;
    assign gpr_wr_addr_o = r_wr_addr;
    assign gpr_wr_data_o = r_wr_data;
    assign busy_o        = r_busy;

endmodule

// File: tb/tb_rv_wb_scoreboard.sv
// Directed scenarios plus a randomized run checked against a cycle-level
// reference model of the write-back merge and busy scoreboard.
module tb_rv_wb_scoreboard;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NR   = 32;

    logic            clk_i = 1'b0;
    logic            arstn_i;
    logic            iss_valid_i, iss_long_i;
    logic [AW-1:0]   iss_rd_i, iss_rs1_i, iss_rs2_i;
    logic            stall_o;
    logic            alu_valid_i;
    logic [AW-1:0]   alu_rd_i;
    logic [XLEN-1:0] alu_data_i;
    logic            lsu_valid_i, lsu_ready_o;
    logic [AW-1:0]   lsu_rd_i;
    logic [XLEN-1:0] lsu_data_i;
    logic            mdu_valid_i, mdu_ready_o;
    logic [AW-1:0]   mdu_rd_i;
    logic [XLEN-1:0] mdu_data_i;
    logic            gpr_wr_en_o;
    logic [AW-1:0]   gpr_wr_addr_o;
    logic [XLEN-1:0] gpr_wr_data_o;
    logic [NR-1:0]   busy_o;

    int total = 0;
    int bad   = 0;

    rv_wb_scoreboard #(.XLEN(XLEN), .GPR_ADDR_W(AW)) dut (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .iss_valid_i(iss_valid_i), .iss_long_i(iss_long_i), .iss_rd_i(iss_rd_i),
        .iss_rs1_i(iss_rs1_i), .iss_rs2_i(iss_rs2_i), .stall_o(stall_o),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i),
        .lsu_data_i(lsu_data_i),
        .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o), .mdu_rd_i(mdu_rd_i),
        .mdu_data_i(mdu_data_i),
        .gpr_wr_en_o(gpr_wr_en_o), .gpr_wr_addr_o(gpr_wr_addr_o),
        .gpr_wr_data_o(gpr_wr_data_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        iss_valid_i = 0; iss_long_i = 0; iss_rd_i = 0; iss_rs1_i = 0; iss_rs2_i = 0;
        alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
        lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
        mdu_valid_i = 0; mdu_rd_i = 0; mdu_data_i = 0;
    endtask

    task automatic test_reset();
        idle();
        arstn_i = 0;
        #3;
        total++;
        if ({gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o} !== {1'b0, 5'd0, 32'd0}) begin
            bad++;
            $display("FAIL reset_wr got=%0b/%0d/%h exp=0/0/0", gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o);
        end
        total++;
        if (busy_o !== 32'd0) begin
            bad++; $display("FAIL reset_busy got=%h exp=0", busy_o);
        end
        total++;
        if ({stall_o, lsu_ready_o, mdu_ready_o} !== 3'b011) begin
            bad++; $display("FAIL reset_comb got=%b exp=011", {stall_o, lsu_ready_o, mdu_ready_o});
        end
        @(negedge clk_i);
        arstn_i = 1;
        tick();
        $display("[reset] released");
    endtask

    task automatic test_alu();
        alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'hDEADBEEF;
        tick();
        idle();
        @(negedge clk_i);
        total++;
        if ({gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL alu_write got=%0b/%0d/%h exp=1/5/deadbeef", gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o);
        end
        tick();
        @(negedge clk_i);
        total++;
        if ({gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL alu_idle got=%0b/%0d/%h exp=0/5/deadbeef", gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o);
        end
        $display("[alu] wr addr=5 data=deadbeef");
        tick();
    endtask

    task automatic test_priority();
        alu_valid_i = 1; alu_rd_i = 3; alu_data_i = 32'hA0A0A0A3;
        lsu_valid_i = 1; lsu_rd_i = 4; lsu_data_i = 32'hB0B0B0B4;
        mdu_valid_i = 1; mdu_rd_i = 6; mdu_data_i = 32'hC0C0C0C6;
        #1;
        total++;
        if ({lsu_ready_o, mdu_ready_o} !== 2'b00) begin
            bad++; $display("FAIL prio_ready0 got=%b exp=00", {lsu_ready_o, mdu_ready_o});
        end
        tick();
        alu_valid_i = 0;
        @(negedge clk_i);
        total++;
        if ({gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o, lsu_ready_o, mdu_ready_o} !==
            {1'b1, 5'd3, 32'hA0A0A0A3, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL prio_first got=%0b/%0d/%h rdy=%b%b exp=1/3/a0a0a0a3 rdy=10",
                     gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o, lsu_ready_o, mdu_ready_o);
        end
        tick();
        lsu_valid_i = 0;
        @(negedge clk_i);
        total++;
        if ({gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o, mdu_ready_o} !==
            {1'b1, 5'd4, 32'hB0B0B0B4, 1'b1}) begin
            bad++;
            $display("FAIL prio_second got=%0b/%0d/%h mrdy=%b exp=1/4/b0b0b0b4 mrdy=1",
                     gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o, mdu_ready_o);
        end
        tick();
        mdu_valid_i = 0;
        @(negedge clk_i);
        total++;
        if ({gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o} !== {1'b1, 5'd6, 32'hC0C0C0C6}) begin
            bad++;
            $display("FAIL prio_third got=%0b/%0d/%h exp=1/6/c0c0c0c6", gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o);
        end
        tick();
        @(negedge clk_i);
        total++;
        if (gpr_wr_en_o !== 1'b0) begin
            bad++; $display("FAIL prio_drain got=%0b exp=0", gpr_wr_en_o);
        end
        $display("[priority] wr order 3,4,6");
        tick();
    endtask

    task automatic test_raw();
        iss_valid_i = 1; iss_long_i = 1; iss_rd_i = 7; iss_rs1_i = 1; iss_rs2_i = 2;
        #1;
        total++;
        if (stall_o !== 1'b0) begin
            bad++; $display("FAIL raw_issue_load got=%0b exp=0", stall_o);
        end
        tick();
        iss_long_i = 0; iss_rd_i = 8; iss_rs1_i = 7; iss_rs2_i = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            total++;
            if ({stall_o, busy_o[7]} !== 2'b11) begin
                bad++; $display("FAIL raw_wait%0d got=stall%0b busy%0b exp=11", i, stall_o, busy_o[7]);
            end
            tick();
        end
        lsu_valid_i = 1; lsu_rd_i = 7; lsu_data_i = 32'h0000_7777;
        tick();
        lsu_valid_i = 0;
        @(negedge clk_i);
        total++;
        if ({gpr_wr_en_o, gpr_wr_addr_o, stall_o, busy_o[7]} !== {1'b1, 5'd7, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL raw_commit_cycle got=en%0b a%0d stall%0b busy%0b exp=en1 a7 stall1 busy1",
                     gpr_wr_en_o, gpr_wr_addr_o, stall_o, busy_o[7]);
        end
        tick();
        @(negedge clk_i);
        total++;
        if ({stall_o, busy_o[7], gpr_wr_en_o} !== 3'b000) begin
            bad++; $display("FAIL raw_release got=stall%0b busy%0b en%0b exp=000", stall_o, busy_o[7], gpr_wr_en_o);
        end
        $display("[raw] x7 load committed, dependent released");
        tick();
        idle();
    endtask

    task automatic test_waw();
        iss_valid_i = 1; iss_long_i = 1; iss_rd_i = 9; iss_rs1_i = 0; iss_rs2_i = 0;
        tick();
        @(negedge clk_i);
        total++;
        if ({stall_o, busy_o} !== {1'b1, 32'h0000_0200}) begin
            bad++; $display("FAIL waw_stall got=stall%0b busy%h exp=stall1 busy00000200", stall_o, busy_o);
        end
        tick();
        iss_rd_i = 0;
        @(negedge clk_i);
        total++;
        if (stall_o !== 1'b0) begin
            bad++; $display("FAIL waw_x0_stall got=%0b exp=0", stall_o);
        end
        tick();
        iss_valid_i = 0;
        mdu_valid_i = 1; mdu_rd_i = 9; mdu_data_i = 32'h9999_0009;
        @(negedge clk_i);
        total++;
        if ({busy_o, mdu_ready_o} !== {32'h0000_0200, 1'b1}) begin
            bad++; $display("FAIL waw_x0_busy got=%h rdy%0b exp=00000200 rdy1", busy_o, mdu_ready_o);
        end
        tick();
        mdu_valid_i = 0;
        iss_valid_i = 1; iss_long_i = 0; iss_rd_i = 9;
        @(negedge clk_i);
        total++;
        if ({stall_o, gpr_wr_en_o, gpr_wr_addr_o} !== {1'b1, 1'b1, 5'd9}) begin
            bad++; $display("FAIL waw_commit got=stall%0b en%0b a%0d exp=stall1 en1 a9", stall_o, gpr_wr_en_o, gpr_wr_addr_o);
        end
        tick();
        @(negedge clk_i);
        total++;
        if ({stall_o, busy_o} !== {1'b0, 32'd0}) begin
            bad++; $display("FAIL waw_release got=stall%0b busy%h exp=stall0 busy0", stall_o, busy_o);
        end
        $display("[waw] x9 second writer released");
        tick();
        idle();
    endtask

    task automatic test_x0_write();
        mdu_valid_i = 1; mdu_rd_i = 0; mdu_data_i = 32'h1234_5678;
        #1;
        total++;
        if (mdu_ready_o !== 1'b1) begin
            bad++; $display("FAIL x0_ready got=%0b exp=1", mdu_ready_o);
        end
        tick();
        mdu_valid_i = 0;
        @(negedge clk_i);
        total++;
        if ({gpr_wr_en_o, gpr_wr_addr_o} !== {1'b0, 5'd0}) begin
            bad++; $display("FAIL x0_no_write got=en%0b a%0d exp=en0 a0", gpr_wr_en_o, gpr_wr_addr_o);
        end
        $display("[x0] mdu handshake, no write");
        tick();
    endtask

    task automatic test_async_reset();
        iss_valid_i = 1; iss_long_i = 1; iss_rd_i = 12; iss_rs1_i = 0; iss_rs2_i = 0;
        alu_valid_i = 1; alu_rd_i = 13; alu_data_i = 32'h1313_1313;
        tick();
        idle();
        lsu_valid_i = 1; lsu_rd_i = 12; lsu_data_i = 32'h1212_1212;
        @(negedge clk_i);
        total++;
        if ({gpr_wr_en_o, busy_o[12]} !== 2'b11) begin
            bad++; $display("FAIL arst_pre got=en%0b busy%0b exp=11", gpr_wr_en_o, busy_o[12]);
        end
        #1 arstn_i = 0;
        #1;
        total++;
        if ({gpr_wr_en_o, busy_o, gpr_wr_data_o} !== {1'b0, 32'd0, 32'd0}) begin
            bad++; $display("FAIL arst_now got=en%0b busy%h d%h exp=0/0/0", gpr_wr_en_o, busy_o, gpr_wr_data_o);
        end
        idle();
        tick();
        arstn_i = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            total++;
            if (gpr_wr_en_o !== 1'b0) begin
                bad++; $display("FAIL arst_quiet%0d got=%0b exp=0", i, gpr_wr_en_o);
            end
            tick();
        end
        alu_valid_i = 1; alu_rd_i = 2; alu_data_i = 32'h2222_2222;
        tick();
        idle();
        @(negedge clk_i);
        total++;
        if ({gpr_wr_en_o, gpr_wr_addr_o} !== {1'b1, 5'd2}) begin
            bad++; $display("FAIL arst_new_acc got=en%0b a%0d exp=en1 a2", gpr_wr_en_o, gpr_wr_addr_o);
        end
        $display("[arst] in-flight state discarded");
        tick();
    endtask

    task automatic test_random();
        logic [NR-1:0]   m_busy;
        logic [NR-1:0]   nb;
        logic            m_wen, m_wlong;
        logic [AW-1:0]   m_waddr;
        logic [XLEN-1:0] m_wdata;
        logic            e_stall, e_lrdy, e_mrdy, lsu_taken, mdu_taken;
        int              writes = 0;

        idle();
        @(negedge clk_i);
        arstn_i = 0;
        @(negedge clk_i);
        arstn_i = 1;
        tick();
        m_busy = '0; m_wen = 0; m_wlong = 0; m_waddr = '0; m_wdata = '0;

        for (int c = 0; c < 400; c++) begin
            alu_valid_i = ($urandom_range(0, 9) < 3);
            alu_rd_i    = AW'($urandom_range(0, 7));
            alu_data_i  = $urandom;
            if (!lsu_valid_i && $urandom_range(0, 9) < 4) begin
                lsu_valid_i = 1; lsu_rd_i = AW'($urandom_range(0, 7)); lsu_data_i = $urandom;
            end
            if (!mdu_valid_i && $urandom_range(0, 9) < 4) begin
                mdu_valid_i = 1; mdu_rd_i = AW'($urandom_range(0, 7)); mdu_data_i = $urandom;
            end
            iss_valid_i = ($urandom_range(0, 9) < 6);
            iss_long_i  = 1'($urandom_range(0, 1));
            iss_rd_i    = AW'($urandom_range(0, 7));
            iss_rs1_i   = AW'($urandom_range(0, 7));
            iss_rs2_i   = AW'($urandom_range(0, 7));
            @(negedge clk_i);

            e_lrdy  = !alu_valid_i;
            e_mrdy  = !alu_valid_i && !lsu_valid_i;
            e_stall = iss_valid_i && (m_busy[iss_rs1_i] || m_busy[iss_rs2_i] || m_busy[iss_rd_i]);
            total++;
            if ({stall_o, lsu_ready_o, mdu_ready_o} !== {e_stall, e_lrdy, e_mrdy}) begin
                bad++; $display("FAIL rnd_comb c=%0d got=%b exp=%b", c,
                                {stall_o, lsu_ready_o, mdu_ready_o}, {e_stall, e_lrdy, e_mrdy});
            end
            total++;
            if ({gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o} !== {m_wen, m_waddr, m_wdata}) begin
                bad++; $display("FAIL rnd_wr c=%0d got=%0b/%0d/%h exp=%0b/%0d/%h", c,
                                gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o, m_wen, m_waddr, m_wdata);
            end
            total++;
            if (busy_o !== m_busy) begin
                bad++; $display("FAIL rnd_busy c=%0d got=%h exp=%h", c, busy_o, m_busy);
            end
            if (m_wen) begin
                writes++;
                $display("[rnd] c=%0d wr x%0d=%h", c, m_waddr, m_wdata);
            end

            lsu_taken = lsu_valid_i && e_lrdy;
            mdu_taken = mdu_valid_i && e_mrdy;
            nb = m_busy;
            if (m_wen && m_wlong && m_busy[m_waddr]) nb[m_waddr] = 1'b0;
            if (iss_valid_i && iss_long_i && !e_stall && iss_rd_i != 0) nb[iss_rd_i] = 1'b1;
            m_busy = nb;
            if (alu_valid_i) begin
                m_wen = (alu_rd_i != 0); m_waddr = alu_rd_i; m_wdata = alu_data_i; m_wlong = 0;
            end else if (lsu_taken) begin
                m_wen = (lsu_rd_i != 0); m_waddr = lsu_rd_i; m_wdata = lsu_data_i; m_wlong = 1;
            end else if (mdu_taken) begin
                m_wen = (mdu_rd_i != 0); m_waddr = mdu_rd_i; m_wdata = mdu_data_i; m_wlong = 1;
            end else begin
                m_wen = 0;
            end

            tick();
            if (lsu_taken) lsu_valid_i = 0;
            if (mdu_taken) mdu_valid_i = 0;
        end
        idle();
        $display("[rnd] %0d writes observed", writes);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_priority();
        test_raw();
        test_waw();
        test_x0_write();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_wb_scoreboard.md
# rv_wb_scoreboard

Write-back merge and hazard scoreboard that sits directly upstream of the general-purpose register file. It collects results from the single-cycle ALU, the load/store unit (LSU) and the multiply/divide unit (MDU), and arbitrates them onto the register file's single write port through one register stage. It also tracks destination registers of in-flight long-latency operations (loads, MUL/DIV) and raises a stall to the issue logic on RAW/WAW hazards against them.

## Interface
- XLEN, 32, data width (rv_pkg)
- GPR_ADDR_W, 5, register address width (rv_gpr_pkg); NUM_REGS = 2**GPR_ADDR_W
- clk_i  input  1  core clock
- arstn_i  input  1  asynchronous, active-low reset
- iss_valid_i  input  1  instruction presented for issue this cycle
- iss_long_i  input  1  issuing instruction is long-latency (load or MDU op)
- iss_rd_i  input  GPR_ADDR_W  destination of issuing instruction
- iss_rs1_i, iss_rs2_i  input  GPR_ADDR_W  sources of issuing instruction
- stall_o  output  1  issue must be held this cycle
- alu_valid_i  input  1  ALU result valid (cannot be back-pressured)
- alu_rd_i  input  GPR_ADDR_W; alu_data_i  input  XLEN
- lsu_valid_i  input  1; lsu_ready_o  output  1; lsu_rd_i  input  GPR_ADDR_W; lsu_data_i  input  XLEN
- mdu_valid_i  input  1; mdu_ready_o  output  1; mdu_rd_i  input  GPR_ADDR_W; mdu_data_i  input  XLEN
- gpr_wr_en_o  output  1; gpr_wr_addr_o  output  GPR_ADDR_W; gpr_wr_data_o  output  XLEN  to register-file write port
- busy_o  output  NUM_REGS  scoreboard vector, bit 0 always 0

## Operation
- Fixed-priority arbitration: ALU > LSU > MDU.
- Ready signals are combinational:
  - lsu_ready_o = !alu_valid_i
  - mdu_ready_o = !alu_valid_i & !lsu_valid_i
- A result is accepted on valid & ready (ALU: on valid). At most one result is accepted per cycle.
- Accepted result is registered:
  - gpr_wr_en_o <= (rd != 0)
  - gpr_wr_addr_o <= rd
  - gpr_wr_data_o <= data
  - A wb_long flag records whether the source was LSU/MDU.
- With no acceptance, gpr_wr_en_o <= 0; addr and data hold.
- Writes to x0 are accepted (handshake completes) but produce gpr_wr_en_o = 0.
- Scoreboard busy[NUM_REGS-1:1]:
  - Set: iss_valid_i & iss_long_i & !stall_o & iss_rd_i != 0.
  - Clear: gpr_wr_en_o & wb_long & busy[gpr_wr_addr_o], i.e. on the edge at which the register file commits the write.
  - Clear and set of the same index on one edge: set wins.
- stall_o = iss_valid_i & (busy[iss_rs1_i] | busy[iss_rs2_i] | busy[iss_rd_i]). It is combinational from registered busy only, with no bypass from pending results.
- Short-op (ALU) RAW hazards are not tracked here; they are resolved by core forwarding.
- A long result whose rd is not busy (e.g. x0) is written normally and clears nothing.

## Timing
- Reset (async, immediate):
  - busy = 0, gpr_wr_en_o = 0, gpr_wr_addr_o = 0, gpr_wr_data_o = 0, wb_long = 0.
  - stall_o, lsu_ready_o and mdu_ready_o then follow their combinational equations.
- Reset mid-operation discards all in-flight results and busy state. No write is emitted after reset release until a new acceptance.
- Latency: result accepted at edge N drives gpr_wr_* during cycle N..N+1; the register file commits at edge N+1.
- Scoreboard bit clears at edge N+1. A dependent instruction stalls through cycle N+1 and issues in cycle N+2, reading the committed value.
- Throughput: one write per cycle. The LSU starves only while the ALU is valid on consecutive cycles. The MDU starves while either is valid.
- Producers must hold valid/rd/data stable until accepted.

## Test plan
- ALU alu_valid_i=1, rd=5, data=0xDEADBEEF at edge 0 -> gpr_wr_en_o=1, addr=5, data=0xDEADBEEF in cycle 1; gpr_wr_en_o=0 in cycle 2.
- ALU, LSU and MDU all valid in one cycle (rd 3, 4, 6) -> ALU written first, lsu_ready_o=0, mdu_ready_o=0. Then LSU next cycle, then MDU. Three consecutive writes in order 3, 4, 6.
- Issue long load to x7, then issue an instruction with rs1=x7 -> stall_o=1 until LSU result for x7 is committed. The cycle after gpr_wr_en_o for x7, busy[7]=0 and stall_o=0.
- Issue long op to rd=x9, then a second long op to rd=x9 -> stall_o=1 (WAW) until the first write commits. Issue with rd=x0, long -> busy unchanged, stall_o=0.
- MDU result to rd=0 with mdu_valid_i=1 -> mdu_ready_o=1, handshake completes, gpr_wr_en_o stays 0.
- Assert arstn_i=0 while busy[12]=1 and LSU valid -> busy_o=0 and gpr_wr_en_o=0 immediately. After release, no write until a new acceptance.
